// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, data-memory wait stalls, and execute redirects.
// A redirect that arrives during a memory wait is replayed. HAZARD_CTRL_PERF_EN adds stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        de_valid_i,
  input  logic [4:0]  de_rs1_idx_i,
  input  logic        de_rs1_used_i,
  input  logic [4:0]  de_rs2_idx_i,
  input  logic        de_rs2_used_i,
  input  logic        ex_valid_i,
  input  logic        ex_mem_rd_i,
  input  logic [4:0]  ex_rd_idx_i,
  input  logic        ex_rd_wr_en_i,
  input  logic        ex_redirect_i,
  input  logic [63:0] ex_target_i,
  input  logic        dmem_req_i,
  input  logic        dmem_gnt_i,
  output logic        fetch_stall_o,
  output logic        decode_stall_o,
  output logic        decode_squash_o,
  output logic        exec_stall_o,
  output logic        exec_squash_o,
  output logic        mem_stall_o,
  output logic        redirect_o,
  output logic [63:0] redirect_pc_o,
  output logic        wait_timeout_o
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REPLAY = 2'd2
  } state_e;

  localparam logic [7:0] LIMIT   = 8'(WAIT_LIMIT);
  localparam logic [7:0] CNT_MAX = 8'hFF;

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic [63:0] pending_pc_q, pending_pc_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;

  logic mem_wait;
  logic load_use;
  logic rs1_hit;
  logic rs2_hit;

  assign mem_wait = dmem_req_i & ~dmem_gnt_i;
  assign rs1_hit  = de_rs1_used_i & (de_rs1_idx_i == ex_rd_idx_i);
  assign rs2_hit  = de_rs2_used_i & (de_rs2_idx_i == ex_rd_idx_i);
  assign load_use = ex_valid_i & ex_mem_rd_i & ex_rd_wr_en_i & (ex_rd_idx_i != 5'd0)
                  & de_valid_i & (rs1_hit | rs2_hit);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      pending_q    <= 1'b0;
      pending_pc_q <= 64'd0;
      wait_cnt_q   <= 8'd0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // Execute is frozen while waiting, so only the first redirect seen in a wait is real.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    pending_pc_d = pending_pc_q;
    wait_cnt_d   = 8'd0;
    timeout_d    = timeout_q;

    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          state_d = ST_WAIT;
          if (ex_redirect_i) begin
            pending_d    = 1'b1;
            pending_pc_d = ex_target_i;
          end
        end
      end
      ST_WAIT: begin
        if (!pending_q && ex_redirect_i) begin
          pending_d    = 1'b1;
          pending_pc_d = ex_target_i;
        end
        if (!mem_wait) begin
          state_d = (pending_q || ex_redirect_i) ? ST_REPLAY : ST_RUN;
        end
      end
      ST_REPLAY: begin
        pending_d    = 1'b0;
        pending_pc_d = 64'd0;
        state_d      = ST_RUN;
      end
      default: begin
        state_d   = ST_RUN;
        pending_d = 1'b0;
      end
    endcase

    if (mem_wait && (state_q == ST_RUN || state_q == ST_WAIT)) begin
      wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 8'd1;
      if (wait_cnt_d >= LIMIT) begin
        timeout_d = 1'b1;
      end
    end
  end

  // Mealy outputs; everything is forced low while reset is held.
  always_comb begin
    fetch_stall_o   = 1'b0;
    decode_stall_o  = 1'b0;
    decode_squash_o = 1'b0;
    exec_stall_o    = 1'b0;
    exec_squash_o   = 1'b0;
    mem_stall_o     = 1'b0;
    redirect_o      = 1'b0;
    redirect_pc_o   = 64'd0;
    wait_timeout_o  = 1'b0;

    if (!rst_i) begin
      wait_timeout_o = timeout_q;
      case (state_q)
        ST_RUN: begin
          if (mem_wait) begin
            fetch_stall_o  = 1'b1;
            decode_stall_o = 1'b1;
            exec_stall_o   = 1'b1;
            mem_stall_o    = 1'b1;
          end else if (ex_redirect_i) begin
            redirect_o      = 1'b1;
            redirect_pc_o   = ex_target_i;
            decode_squash_o = 1'b1;
            exec_squash_o   = 1'b1;
          end else if (load_use) begin
            fetch_stall_o  = 1'b1;
            decode_stall_o = 1'b1;
            exec_squash_o  = 1'b1;
          end
        end
        ST_WAIT: begin
          if (mem_wait) begin
            fetch_stall_o  = 1'b1;
            decode_stall_o = 1'b1;
            exec_stall_o   = 1'b1;
            mem_stall_o    = 1'b1;
          end
        end
        ST_REPLAY: begin
          redirect_o      = 1'b1;
          redirect_pc_o   = pending_pc_q;
          decode_squash_o = 1'b1;
          exec_squash_o   = 1'b1;
        end
        default: begin
          fetch_stall_o = 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (fetch_stall_o) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (redirect_o) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer that generates stall, squash and redirect controls for fetch, decode, execute and memory stages.
- Resolves load-use hazards, data-memory wait states, and branch/jump redirects from execute. A redirect that coincides with a memory wait is held pending and replayed.
- Drives the decode stage stall_i/squash_i pins and the fetch stage redirect inputs.

Parameters:
- WAIT_LIMIT, 255, memory-wait cycles after which the sticky timeout flag sets (1..255).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- de_valid_i  in  1  instruction in decode is valid
- de_rs1_idx_i  in  5  decode rs1 index (async, from inst)
- de_rs1_used_i  in  1  decode instruction reads rs1
- de_rs2_idx_i  in  5  decode rs2 index
- de_rs2_used_i  in  1  decode instruction reads rs2
- ex_valid_i  in  1  execute-stage instruction valid
- ex_mem_rd_i  in  1  execute instruction is a load
- ex_rd_idx_i  in  5  execute destination index
- ex_rd_wr_en_i  in  1  execute writes rd
- ex_redirect_i  in  1  execute resolved taken branch/jump
- ex_target_i  in  64  redirect target PC
- dmem_req_i  in  1  memory stage has outstanding data request
- dmem_gnt_i  in  1  data memory accepts/completes request this cycle
- fetch_stall_o  out  1  hold fetch
- decode_stall_o  out  1  hold decode registers
- decode_squash_o  out  1  invalidate instruction entering decode
- exec_stall_o  out  1  hold execute registers
- exec_squash_o  out  1  insert bubble into execute
- mem_stall_o  out  1  hold memory stage
- redirect_o  out  1  fetch loads redirect_pc_o
- redirect_pc_o  out  64  redirect target
- wait_timeout_o  out  1  sticky: wait exceeded WAIT_LIMIT

Behaviour:
- Reset (async, rst_i=1): state RUN, pending flag 0, pending PC 0, wait counter 0, wait_timeout_o 0. All outputs read 0 while reset is asserted. Reset mid-WAIT or mid-REPLAY returns to RUN immediately and drops any pending redirect.
- Outputs are Mealy: combinational from state, registers and current inputs. Zero-cycle latency.
- mem_wait = dmem_req_i & ~dmem_gnt_i.
- load_use = ex_valid_i & ex_mem_rd_i & ex_rd_wr_en_i & (ex_rd_idx_i!=0) & de_valid_i & ((de_rs1_used_i & de_rs1_idx_i==ex_rd_idx_i) | (de_rs2_used_i & de_rs2_idx_i==ex_rd_idx_i)).
- RUN: priority is mem_wait > redirect > load_use.
  - mem_wait: all four stall outputs=1, squash/redirect=0. Next state WAIT. If ex_redirect_i is also 1, latch pending=1 and pending PC=ex_target_i.
  - redirect: redirect_o=1, redirect_pc_o=ex_target_i, decode_squash_o=1, exec_squash_o=1. No stalls. Stay in RUN.
  - load_use: fetch_stall_o=decode_stall_o=1, exec_squash_o=1. One bubble per detection. Stay in RUN.
  - otherwise all outputs 0.
- WAIT: all four stalls=1 while mem_wait. Wait counter increments, saturating at 255. When counter reaches WAIT_LIMIT, wait_timeout_o sets; it clears only on reset. A redirect arriving in WAIT with pending=0 is latched; a second one is ignored because execute is frozen. On ~mem_wait, the counter clears; go to REPLAY if pending, else RUN. Stalls are 0 in the exit cycle.
- REPLAY (one cycle): redirect_o=1, redirect_pc_o=pending PC, decode_squash_o=exec_squash_o=1. Pending clears. Next state RUN. Load-use is ignored in this cycle; the squashed instruction is wrong-path.
- redirect_pc_o is 0 whenever redirect_o=0.
- Stall and squash may both be asserted to decode. Squash takes effect on the next stall release.

Optional Feature:
- Macro HAZARD_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cnt_o[31:0] and perf_flush_cnt_o[31:0].
  - perf_stall_cnt_o counts cycles with fetch_stall_o=1.
  - perf_flush_cnt_o counts cycles with redirect_o=1.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Load x5 in execute, decode reads rs2=x5 and rs2_used=1 -> exactly one cycle of fetch/decode stall plus exec_squash_o=1; x0 as rd -> no stall.
- dmem_req_i=1, dmem_gnt_i=0 for 3 cycles, then gnt -> all stalls high for 3 cycles and low on the gnt cycle; state returns to RUN.
- ex_redirect_i=1 with target 0x8000_0040 in RUN -> same-cycle redirect_o=1, redirect_pc_o=0x8000_0040, both squashes=1.
- Redirect (target 0x1000) coincident with first mem_wait cycle, wait lasts 2 cycles -> no redirect during wait; one REPLAY cycle after release with redirect_pc_o=0x1000.
- WAIT_LIMIT=4, gnt withheld 6 cycles -> wait_timeout_o rises after the 4th wait cycle and stays high after release; rst_i clears it.
- Assert rst_i during WAIT with a pending redirect -> outputs 0 immediately; after release no REPLAY occurs. With HAZARD_CTRL_PERF_EN defined, the counters read 0.
